camera_config_sequencer: RTL and testbench
==========================================

// Module: camera_config_sequencer
// PURPOSE
//  Downstream of the Avalon camera register bank. Turns the exported 16-bit camera
//  settings into sensor register writes, issued one at a time to the I2C write master.
//  Does a full sweep after reset and after a soft-reset release, then rewrites only changed settings.
// PARAMETERS
//  POWERUP_CYCLES  50000  clk cycles to wait after reset before the first sweep
//  ACK_TIMEOUT     65535  clk cycles to wait for wr_ack before counting a failed attempt
//  MAX_RETRY       3      retries per entry after a failed first attempt (total attempts = MAX_RETRY+1)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  cam_soft_reset_n  in   1   soft reset from register bank; low = hold off
//  start_row         in   16  -> sensor reg 0x01
//  start_column      in   16  -> sensor reg 0x02
//  row_size          in   16  -> sensor reg 0x03
//  column_size       in   16  -> sensor reg 0x04
//  h_blanking        in   16  -> sensor reg 0x05
//  v_blanking        in   16  -> sensor reg 0x06
//  exposure          in   16  -> sensor reg 0x09
//  row_mode          in   16  -> sensor reg 0x22
//  column_mode       in   16  -> sensor reg 0x23
//  green1_gain       in   16  -> sensor reg 0x2B
//  blue_gain         in   16  -> sensor reg 0x2C
//  red_gain          in   16  -> sensor reg 0x2D
//  green2_gain       in   16  -> sensor reg 0x2E
//  wr_req            out  1   write request to I2C master
//  wr_addr           out  8   sensor register address
//  wr_data           out  16  sensor register data
//  wr_ack            in   1   one-cycle pulse: transaction finished
//  wr_err            in   1   qualified by wr_ack; 1 = slave NACK
//  busy              out  1   high in every state except IDLE
//  config_done       out  1   high when no entry is dirty and state is IDLE
//  cfg_error         out  1   sticky; set when an entry exhausts its retries
// BEHAVIOUR
//  Entry table, index 0..12 in port order above. Each entry has a dirty bit and a 16-bit shadow.
//  Reset state: wr_req=0, wr_addr=0, wr_data=0, busy=1, config_done=0, cfg_error=0.
//   All dirty bits are set. State is PWRUP and the delay counter is 0.
//  Reset overrides everything, including a transaction that is in flight.
//  PWRUP: count to POWERUP_CYCLES-1, then go to SCAN.
//  SCAN: pick the lowest-index dirty entry. If one exists, clear its dirty bit, latch its input
//   value into wr_data and its shadow, and go to REQ. If none exists, go to IDLE.
//  REQ: wr_req=1 with wr_addr/wr_data held stable. Clear the timeout counter. Go to WAIT.
//  WAIT: wr_req stays high until the ack cycle, then drops.
//   On wr_ack && !wr_err: go to SCAN.
//   On wr_ack && wr_err, or timeout reached: retry (back to REQ) if the attempt count is <= MAX_RETRY.
//   Otherwise set cfg_error and go to SCAN; the entry stays clean.
//  IDLE: wr_req=0, busy=0.
//  Change detect, every cycle in any state except PWRUP:
//   input != shadow sets that entry's dirty bit.
//   An input that changes during its own transaction re-dirties the entry, so it is rewritten later.
//   IDLE goes to SCAN the cycle after any dirty bit is set.
//  Soft reset:
//   While cam_soft_reset_n=0, SCAN does not start new entries; an in-flight transaction completes.
//   On its 0->1 edge, set all dirty bits, which forces a full sweep.
//  Latency: an IDLE input change gives wr_req high 3 cycles later (dirty, SCAN, REQ).
//  Simultaneous dirty set and clear on the same entry: set wins.
// TESTING
//  1. Reset, POWERUP_CYCLES=10, ack every request 5 cycles later -> 13 writes in address order
//     0x01..0x2E with defaults. config_done=1 after the last ack.
//  2. In IDLE, exposure 0x07C0->0x0100 -> exactly one write {0x09,0x0100}. wr_req rises 3 cycles
//     after the change.
//  3. wr_err=1 on every ack of reg 0x2D, MAX_RETRY=3 -> 4 attempts, cfg_error=1, and the sweep
//     continues with 0x2E.
//  4. No ack, ACK_TIMEOUT=20 -> each attempt lasts 21 cycles in WAIT, then retry follows the same
//     rules as scenario 3.
//  5. cam_soft_reset_n 1->0 during the 0x03 write -> the 0x03 write completes and no further
//     requests are issued. Release -> full 13-entry sweep.
//  6. Change red_gain while its write is pending -> entry rewritten with the new value after the
//     current ack. Assert reset mid-WAIT -> wr_req=0 the next cycle.

Source files
------------

// File: rtl/camera_config_sequencer.sv
// Turns the 13 exported camera settings into sensor register writes for the I2C write master.
// Full sweep after reset and after soft-reset release; afterwards only changed settings are rewritten.
module camera_config_sequencer #(
  parameter int POWERUP_CYCLES = 50000,
  parameter int ACK_TIMEOUT    = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_soft_reset_n,
  input  logic [15:0] start_row,
  input  logic [15:0] start_column,
  input  logic [15:0] row_size,
  input  logic [15:0] column_size,
  input  logic [15:0] h_blanking,
  input  logic [15:0] v_blanking,
  input  logic [15:0] exposure,
  input  logic [15:0] row_mode,
  input  logic [15:0] column_mode,
  input  logic [15:0] green1_gain,
  input  logic [15:0] blue_gain,
  input  logic [15:0] red_gain,
  input  logic [15:0] green2_gain,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  input  logic        wr_err,
  output logic        busy,
  output logic        config_done,
  output logic        cfg_error
);

  localparam int NUM_ENTRIES = 13;
  localparam int IDX_W = 4;
  localparam int PWR_W = $clog2(POWERUP_CYCLES + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int ATT_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SCAN,
    S_REQ,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t state, state_next;

  logic [15:0]            cfg_val [NUM_ENTRIES];
  logic [15:0]            shadow  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] dirty, dirty_next;
  logic [PWR_W-1:0]       pwr_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [ATT_W-1:0]       attempt_cnt;
  logic                   soft_q;
  logic                   soft_rise;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   start_entry;
  logic                   retry;
  logic                   give_up;
  logic                   leave_wait;
  logic                   timed_out;

  assign cfg_val[0]  = start_row;
  assign cfg_val[1]  = start_column;
  assign cfg_val[2]  = row_size;
  assign cfg_val[3]  = column_size;
  assign cfg_val[4]  = h_blanking;
  assign cfg_val[5]  = v_blanking;
  assign cfg_val[6]  = exposure;
  assign cfg_val[7]  = row_mode;
  assign cfg_val[8]  = column_mode;
  assign cfg_val[9]  = green1_gain;
  assign cfg_val[10] = blue_gain;
  assign cfg_val[11] = red_gain;
  assign cfg_val[12] = green2_gain;

  function automatic logic [7:0] entry_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h03;
      4'd3:    return 8'h04;
      4'd4:    return 8'h05;
      4'd5:    return 8'h06;
      4'd6:    return 8'h09;
      4'd7:    return 8'h22;
      4'd8:    return 8'h23;
      4'd9:    return 8'h2B;
      4'd10:   return 8'h2C;
      4'd11:   return 8'h2D;
      4'd12:   return 8'h2E;
      default: return 8'h00;
    endcase
  endfunction

  assign soft_rise   = cam_soft_reset_n && !soft_q;
  assign busy        = (state != S_IDLE);
  assign config_done = (state == S_IDLE) && (dirty == '0);
  assign timed_out   = (tmo_cnt == TMO_W'(ACK_TIMEOUT));

  // Lowest-index dirty entry wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next  = state;
    start_entry = 1'b0;
    retry       = 1'b0;
    give_up     = 1'b0;
    leave_wait  = 1'b0;
    case (state)
      S_PWRUP: begin
        if (pwr_cnt == PWR_W'(POWERUP_CYCLES - 1)) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (pick_valid && cam_soft_reset_n) begin
          start_entry = 1'b1;
          state_next  = S_REQ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_REQ: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wr_ack && !wr_err) begin
          leave_wait = 1'b1;
          state_next = S_SCAN;
        end else if (wr_ack || timed_out) begin
          leave_wait = 1'b1;
          if (attempt_cnt <= ATT_W'(MAX_RETRY)) begin
            retry      = 1'b1;
            state_next = S_REQ;
          end else begin
            give_up    = 1'b1;
            state_next = S_SCAN;
          end
        end
      end
      S_IDLE: begin
        if ((dirty != '0) && cam_soft_reset_n) state_next = S_SCAN;
      end
      default: state_next = S_PWRUP;
    endcase
  end

  // wr_req drops for one cycle after every ack or timeout, so a retry is a fresh request edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PWRUP;
      pwr_cnt     <= '0;
      tmo_cnt     <= '0;
      attempt_cnt <= '0;
      soft_q      <= 1'b1;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cfg_error   <= 1'b0;
    end else begin
      state  <= state_next;
      soft_q <= cam_soft_reset_n;
      if (state == S_PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      if (state == S_REQ) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (start_entry || state == S_REQ) begin
        wr_req <= 1'b1;
      end else if (leave_wait) begin
        wr_req <= 1'b0;
      end
      if (start_entry) begin
        wr_addr     <= entry_addr(pick_idx);
        wr_data     <= cfg_val[pick_idx];
        attempt_cnt <= ATT_W'(1);
      end else if (retry) begin
        attempt_cnt <= attempt_cnt + 1'b1;
      end
      if (give_up) cfg_error <= 1'b1;
    end
  end

  // The entry being launched is excluded from change detect, since its shadow takes this very value.
  always_comb begin
    dirty_next = dirty;
    if (start_entry) dirty_next[pick_idx] = 1'b0;
    if (state != S_PWRUP) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((cfg_val[i] != shadow[i]) && !(start_entry && (pick_idx == IDX_W'(i)))) begin
          dirty_next[i] = 1'b1;
        end
      end
    end
    if (soft_rise) dirty_next = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= '1;
      for (int i = 0; i < NUM_ENTRIES; i++) shadow[i] <= '0;
    end else begin
      dirty <= dirty_next;
      if (start_entry) shadow[pick_idx] <= cfg_val[pick_idx];
    end
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Scoreboard bench for camera_config_sequencer: expected writes are queued by the stimulus
// and popped by a monitor on every rising wr_req; an I2C master model answers requests.
module tb_camera_config_sequencer;

  localparam int POWERUP_CYCLES = 10;
  localparam int ACK_TIMEOUT    = 20;
  localparam int MAX_RETRY      = 3;
  localparam int ACK_DELAY      = 5;

  localparam logic [7:0] ADDR [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h09,
                                       8'h22, 8'h23, 8'h2B, 8'h2C, 8'h2D, 8'h2E};
  localparam logic [15:0] DEFAULTS [13] = '{16'h0036, 16'h0010, 16'h0797, 16'h0A1F, 16'h0000,
                                            16'h0019, 16'h07C0, 16'h0000, 16'h0000, 16'h0013,
                                            16'h0019, 16'h0017, 16'h0013};

  logic        clk = 1'b0;
  logic        reset;
  logic        cam_soft_reset_n;
  logic [15:0] cfg [13];
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        busy;
  logic        config_done;
  logic        cfg_error;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q [$];
  logic        ack_enable;
  logic [7:0]  err_addr;

  always #5 clk = ~clk;

  camera_config_sequencer #(
    .POWERUP_CYCLES(POWERUP_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cam_soft_reset_n(cam_soft_reset_n),
    .start_row(cfg[0]),
    .start_column(cfg[1]),
    .row_size(cfg[2]),
    .column_size(cfg[3]),
    .h_blanking(cfg[4]),
    .v_blanking(cfg[5]),
    .exposure(cfg[6]),
    .row_mode(cfg[7]),
    .column_mode(cfg[8]),
    .green1_gain(cfg[9]),
    .blue_gain(cfg[10]),
    .red_gain(cfg[11]),
    .green2_gain(cfg[12]),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .busy(busy),
    .config_done(config_done),
    .cfg_error(cfg_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one setting and queues the write(s) it should provoke.
  task automatic applyStimulus(input int idx, input logic [15:0] value, input int writes);
    cfg[idx] = value;
    for (int k = 0; k < writes; k++) exp_q.push_back({ADDR[idx], value});
  endtask

  task automatic pushEntry(input int idx);
    exp_q.push_back({ADDR[idx], cfg[idx]});
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(config_done && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_config_done"}, 32'(config_done), 32'd1);
    checkOutput({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every new request is compared against the head of the queue.
  initial begin : monitor
    logic        prev;
    logic [23:0] exp_w;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (wr_req && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual=0x%0h%04h required=none", wr_addr, wr_data);
          end else begin
            exp_w = exp_q.pop_front();
            checkOutput("write", {8'h00, wr_addr, wr_data}, {8'h00, exp_w});
          end
        end
        prev = wr_req;
      end
    end
  end

  // I2C master model: acks ACK_DELAY cycles after a request edge, NACKs err_addr.
  initial begin : master
    int   delay;
    logic active;
    logic prev;
    active = 1'b0;
    prev   = 1'b0;
    delay  = 0;
    wr_ack = 1'b0;
    wr_err = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      wr_err = 1'b0;
      if (reset) begin
        active = 1'b0;
        prev   = 1'b0;
      end else begin
        if (active) begin
          delay++;
          if (delay == ACK_DELAY) begin
            wr_ack = 1'b1;
            wr_err = (wr_addr == err_addr);
            active = 1'b0;
          end
        end else if (wr_req && !prev && ack_enable) begin
          active = 1'b1;
          delay  = 0;
        end
        prev = wr_req;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : stimulus
    int n;
    int width;
    reset            = 1'b1;
    cam_soft_reset_n = 1'b1;
    ack_enable       = 1'b1;
    err_addr         = 8'h00;
    for (int i = 0; i < 13; i++) cfg[i] = DEFAULTS[i];
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset_wr_req", 32'(wr_req), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_config_done", 32'(config_done), 32'd0);
    checkOutput("reset_cfg_error", 32'(cfg_error), 32'd0);

    $display("[TB] power-up sweep");
    for (int i = 0; i < 13; i++) pushEntry(i);
    reset = 1'b0;
    n = 0;
    while (!wr_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("powerup_latency", 32'(n), 32'(POWERUP_CYCLES + 1));
    waitDone("sweep", 400);
    checkOutput("sweep_cfg_error", 32'(cfg_error), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] single change in idle");
    @(negedge clk);
    applyStimulus(6, 16'h0100, 1);
    n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("change_latency", 32'(n), 32'd3);
    waitDone("exposure", 100);

    $display("[TB] NACK retries");
    @(negedge clk);
    err_addr = 8'h2D;
    applyStimulus(11, 16'h0020, MAX_RETRY + 1);
    applyStimulus(12, 16'h0021, 1);
    waitDone("nack", 300);
    checkOutput("nack_cfg_error", 32'(cfg_error), 32'd1);
    err_addr = 8'h00;

    $display("[TB] ack timeout retries");
    @(negedge clk);
    ack_enable = 1'b0;
    applyStimulus(7, 16'h0011, MAX_RETRY + 1);
    for (int k = 0; k <= MAX_RETRY; k++) begin
      n = 0;
      while (!wr_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      width = 0;
      while (wr_req && width < 60) begin
        @(negedge clk);
        width++;
      end
      checkOutput($sformatf("timeout_req_width_%0d", k), 32'(width),
                  (k == 0) ? 32'(ACK_TIMEOUT + 2) : 32'(ACK_TIMEOUT + 1));
    end
    waitDone("timeout", 100);
    checkOutput("timeout_cfg_error", 32'(cfg_error), 32'd1);
    ack_enable = 1'b1;

    $display("[TB] soft reset hold and release");
    @(negedge clk);
    cam_soft_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("soft_low_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) pushEntry(i);
    cam_soft_reset_n = 1'b1;
    n = 0;
    while (!(wr_req && wr_addr == 8'h03) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("soft_reached_reg03", 32'(wr_addr), 32'h03);
    cam_soft_reset_n = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("soft_hold_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("soft_hold_wr_req", 32'(wr_req), 32'd0);
    checkOutput("soft_hold_busy", 32'(busy), 32'd0);
    checkOutput("soft_hold_config_done", 32'(config_done), 32'd0);
    for (int i = 0; i < 13; i++) pushEntry(i);
    cam_soft_reset_n = 1'b1;
    waitDone("soft_sweep", 400);

    $display("[TB] change while pending");
    @(negedge clk);
    applyStimulus(11, 16'h0030, 1);
    n = 0;
    while (!(wr_req && wr_addr == 8'h2D) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_reached_reg2d", 32'(wr_addr), 32'h2D);
    @(negedge clk);
    applyStimulus(11, 16'h0031, 1);
    waitDone("pending_change", 100);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    applyStimulus(6, 16'h0200, 1);
    n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midwait_reset_wr_req", 32'(wr_req), 32'd0);
    checkOutput("midwait_reset_busy", 32'(busy), 32'd1);
    checkOutput("midwait_reset_cfg_error", 32'(cfg_error), 32'd0);
    checkOutput("midwait_reset_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 13; i++) pushEntry(i);
    reset = 1'b0;
    waitDone("post_reset_sweep", 400);
    checkOutput("post_reset_cfg_error", 32'(cfg_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
